// File: rtl/if_inst_queue_if.sv
// Handshake bundle between pre-IF, the I$ response port, the IF instruction
// queue and the ID stage. The queue uses the slave modport; the side that
// drives fetch requests, I$ responses and ID back-pressure uses master.
interface if_inst_queue_if #(
    parameter int EXC_W = 19
);
    logic             flush;
    logic             req_fire;
    logic [31:0]      req_pc;
    logic [EXC_W-1:0] req_except;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             q_full;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic [EXC_W-1:0] id_except;

    modport master (
        output flush, req_fire, req_pc, req_except, resp_valid, resp_rdata, id_ready,
        input  q_full, id_valid, id_pc, id_instr, id_except
    );

    modport slave (
        input  flush, req_fire, req_pc, req_except, resp_valid, resp_rdata, id_ready,
        output q_full, id_valid, id_pc, id_instr, id_except
    );
endinterface

// File: rtl/if_inst_queue.sv
// IF-stage instruction queue. One in-order slot is allocated per accepted
// fetch, filled when the I$ answers (responses arrive in request order), and
// handed to ID through id_valid/id_ready. After a flush, responses still in
// flight for discarded slots are counted in drop_cnt and swallowed.
// Optional macro IFQ_BYPASS_EN: a response that fills the head slot is
// presented to ID in the same cycle; without it the response is registered
// first and reaches ID one cycle later.
module if_inst_queue #(
    parameter int DEPTH = 4,
    parameter int EXC_W = 19
) (
    input logic            clk,
    input logic            rst,
    if_inst_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wide_cnt_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [EXC_W-1:0] except;
    } slot_data_t;

    slot_data_t       slot_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_done;
    ptr_t             head;
    ptr_t             tail;
    cnt_t             count;
    cnt_t             drop_cnt;
    logic             q_full_r;

    logic      fill_found;
    ptr_t      fill_idx;
    cnt_t      pending;
    logic      resp_take;
    logic      fill_en;
    logic      bypass_hit;
    logic      id_valid_c;
    logic      enq;
    logic      deq;
    logic      resp_sub;
    cnt_t      count_next;
    wide_cnt_t drop_sum;

    // Locate the oldest allocated slot still waiting for I$ data and count all such slots.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fill_found = 1'b0;
        fill_idx   = head;
        pending    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_found && slot_valid[head + ptr_t'(i)] && !slot_done[head + ptr_t'(i)]) begin
                fill_found = 1'b1;
                fill_idx   = head + ptr_t'(i);
            end
            pending = pending + cnt_t'(slot_valid[i] & ~slot_done[i]);
        end
    end

    // Per-cycle control: enqueue, fill, dequeue, occupancy and drop bookkeeping.
    always_comb begin
        enq       = bus.req_fire && !bus.flush && !q_full_r;
        resp_take = bus.resp_valid && (drop_cnt == '0) && !bus.flush;
        fill_en   = resp_take && fill_found;
`ifdef IFQ_BYPASS_EN
        bypass_hit = fill_en && (fill_idx == head);
`else
        bypass_hit = 1'b0;
`endif
        id_valid_c = !bus.flush && slot_valid[head] && (slot_done[head] || bypass_hit);
        deq        = id_valid_c && bus.id_ready;
        count_next = bus.flush ? '0 : count + cnt_t'(enq) - cnt_t'(deq);
        // A response landing in the flush cycle with nothing left to drop belongs to
        // one of the pending slots being discarded, so it cancels that slot's count.
        resp_sub   = bus.resp_valid && ((drop_cnt != '0) || bus.flush);
        drop_sum   = wide_cnt_t'(drop_cnt)
                   + (bus.flush ? wide_cnt_t'(pending) : '0)
                   - wide_cnt_t'(resp_sub);
    end

    // Head-slot presentation to ID; payload is zeroed whenever nothing is offered.
    always_comb begin
        bus.q_full    = q_full_r;
        bus.id_valid  = id_valid_c;
        bus.id_pc     = '0;
        bus.id_instr  = '0;
        bus.id_except = '0;
        if (id_valid_c) begin
            bus.id_pc     = slot_data[head].pc;
            bus.id_instr  = bypass_hit ? bus.resp_rdata : slot_data[head].instr;
            bus.id_except = slot_data[head].except;
        end
    end

    // Slot payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload RAM is not reset; valid/done gate every read and enqueue rewrites all fields.
        if (enq) begin
            slot_data[tail].pc     <= bus.req_pc;
            slot_data[tail].except <= bus.req_except;
            slot_data[tail].instr  <= '0;
        end
        if (fill_en && !(bypass_hit && deq)) begin
            slot_data[fill_idx].instr <= bus.resp_rdata;
        end
    end

    // Slot status, ring pointers, occupancy, full flag and drop counter.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
        if (rst) begin
            slot_valid <= '0;
            slot_done  <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            q_full_r   <= 1'b0;
        end else begin
            if (bus.flush) begin
                slot_valid <= '0;
                head       <= '0;
                tail       <= '0;
            end else begin
                if (enq) begin
                    slot_valid[tail] <= 1'b1;
                    slot_done[tail]  <= |bus.req_except;
                    tail             <= tail + 1'b1;
                end
                if (fill_en) begin
                    slot_done[fill_idx] <= 1'b1;
                end
                if (deq) begin
                    slot_valid[head] <= 1'b0;
                    head             <= head + 1'b1;
                end
            end
            count    <= count_next;
            drop_cnt <= drop_sum[CNT_W-1:0];
            q_full_r <= (count_next == cnt_t'(DEPTH));
        end
    end

    // Protocol checks on pre-IF and I$ behaviour.
    a_no_req_when_full : assert property (@(posedge clk) disable iff (rst)
        !(bus.req_fire && q_full_r))
        else $error("if_inst_queue: req_fire asserted while q_full");

    a_resp_has_target : assert property (@(posedge clk) disable iff (rst)
        !(resp_take && !fill_found))
        else $error("if_inst_queue: I$ response with no outstanding slot");

    a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
        drop_sum <= wide_cnt_t'(DEPTH))
        else $error("if_inst_queue: drop counter out of range");
endmodule
